// File: rtl/regfile_dump_reader.sv
// Debug read-side master for the CPU register file.
// Walks a register index range on a start pulse and streams each
// (index, value) pair out over a valid/ready handshake, using only the
// combinational read port so the datapath write port is never touched.
//
// Handshake: out_valid rises with a complete beat (out_index, out_data,
// out_last). While out_valid=1 and out_ready=0 every beat field is held
// stable. A beat transfers on any rising edge where out_valid&&out_ready.
// out_valid never drops without a transfer, except on reset.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              range_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    // NUM_REGS widened by one bit so last_addr == 2**ADDR_W-1 still compares correctly.
    localparam logic [ADDR_W:0] NUM_REGS_EXT = (ADDR_W + 1)'(NUM_REGS);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              range_err_q, range_err_d;

    logic range_ok;

    // A request is legal only for a non-empty, in-bounds, non-wrapping range.
    always_comb begin
        range_ok = (first_addr <= last_addr) && ({1'b0, last_addr} < NUM_REGS_EXT);
    end

    // Next-state and next-output computation for the dump sequencer.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        rd_addr_d   = rd_addr_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        range_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (range_ok) begin
                        last_d    = last_addr;
                        rd_addr_d = first_addr;
                        busy_d    = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        done_d      = 1'b1;
                        range_err_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                // Snapshot point: the value present on rd_data before this edge is the beat.
                out_data_d  = rd_data;
                out_index_d = rd_addr_q;
                out_last_d  = (rd_addr_q == last_q);
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        // Address stays at last_q so a full-range dump never wraps.
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        state_d   = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any dump without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            rd_addr_q   <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            rd_addr_q   <= rd_addr_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
        end
    end

    assign busy      = busy_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a register-file model with a write port,
// a table of dump requests, hand-written multi-cycle sequences and a
// scoreboard of expected beats checked on every handshake.
module tb_regfile_dump_reader;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_addr, last_addr;
    logic          busy, out_valid, out_ready, out_last, done, range_err;
    logic [AW-1:0] rd_addr, out_index;
    logic [DW-1:0] rd_data, out_data;

    // Second instance with a 16-entry file to reach out-of-range last_addr values.
    logic          s_start;
    logic [AW-1:0] s_first, s_last;
    logic          s_busy, s_out_valid, s_out_last, s_done, s_range_err;
    logic [AW-1:0] s_rd_addr, s_out_index;
    logic [DW-1:0] s_rd_data, s_out_data;

    // Register file model: combinational read, write on the rising edge.
    logic [DW-1:0] regs [32];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    assign rd_data   = regs[rd_addr];
    assign s_rd_data = regs[s_rd_addr];

    always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;

    always #5 clk = ~clk;

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
        .out_last(out_last), .done(done), .range_err(range_err)
    );

    regfile_dump_reader #(.NUM_REGS(16), .ADDR_W(AW), .DATA_W(DW)) dut16 (
        .clk(clk), .rst(rst), .start(s_start), .first_addr(s_first), .last_addr(s_last),
        .busy(s_busy), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .out_valid(s_out_valid),
        .out_ready(1'b1), .out_index(s_out_index), .out_data(s_out_data),
        .out_last(s_out_last), .done(s_done), .range_err(s_range_err)
    );

    // Scoreboard and bookkeeping
    logic [AW+DW:0] exp_q [$];
    int             hs_q [$];
    int             tests = 0;
    int             fails = 0;
    int             beat_cnt = 0;
    int             done_cnt = 0;
    int             cyc = 0;
    int             start_cyc = 0;
    bit             prev_stall = 0;
    logic [AW+DW:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid low-phase, after drivers have settled.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (done) check("done_excl_valid", out_valid, 0);
            if (prev_stall && out_valid) check("stall_hold", {out_index, out_data, out_last}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: actual index=%0d data=%0h expected no beat", out_index, out_data);
                end else begin
                    check("beat", {out_index, out_data, out_last}, exp_q.pop_front());
                end
                beat_cnt++;
                hs_q.push_back(cyc - start_cyc);
            end
            if (done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            held       = {out_index, out_data, out_last};
        end else begin
            prev_stall = 0;
        end
    end

    task automatic push_range(input logic [AW-1:0] f, input logic [AW-1:0] l);
        for (int i = int'(f); i <= int'(l); i++)
            exp_q.push_back({i[AW-1:0], regs[i], (i == int'(l))});
    endtask

    // Issue one dump request and wait for it to finish.
    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input bit stall,
                            input bit exp_err, input int exp_beats);
        int  b0;
        int  d0;
        bit  got;
        b0  = beat_cnt;
        d0  = done_cnt;
        got = 0;
        if (!exp_err) push_range(f, l);
        @(negedge clk);
        start = 1; first_addr = f; last_addr = l; out_ready = 1;
        @(negedge clk);
        start = 0;
        check("start_busy", busy, !exp_err);
        check("start_done", done, exp_err);
        check("start_range_err", range_err, exp_err);
        if (exp_err) begin
            got = 1;
            @(negedge clk);
            check("err_done_one_cycle", done, 0);
            check("err_busy_low", busy, 0);
        end else begin
            for (int n = 0; n < 400; n++) begin
                out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                if (done) begin
                    got = 1;
                    check("end_range_err", range_err, 0);
                    check("end_busy", busy, 0);
                    check("end_rd_addr", rd_addr, l);
                    break;
                end
            end
        end
        #3;
        check("dump_finished", got, 1);
        check("beat_count", beat_cnt - b0, exp_beats);
        check("done_count", done_cnt - d0, 1);
        check("queue_empty", exp_q.size(), 0);
        out_ready = 1;
    endtask

    typedef struct {
        logic [AW-1:0] first;
        logic [AW-1:0] last;
        bit            stall;
        bit            exp_err;
        int            exp_beats;
    } vec_t;

    vec_t vecs [9];

    initial begin
        bit pat [5];
        int p;
        bit seen;
        int done_rel;

        vecs[0] = '{5'd1,  5'd3,  1'b0, 1'b0, 3};
        vecs[1] = '{5'd0,  5'd31, 1'b0, 1'b0, 32};
        vecs[2] = '{5'd5,  5'd6,  1'b1, 1'b0, 2};
        vecs[3] = '{5'd7,  5'd2,  1'b0, 1'b1, 0};
        vecs[4] = '{5'd9,  5'd9,  1'b0, 1'b0, 1};
        vecs[5] = '{5'd31, 5'd31, 1'b1, 1'b0, 1};
        vecs[6] = '{5'd0,  5'd0,  1'b0, 1'b0, 1};
        vecs[7] = '{5'd3,  5'd2,  1'b0, 1'b1, 0};
        vecs[8] = '{5'd10, 5'd20, 1'b1, 1'b0, 11};

        rst = 1; start = 0; first_addr = 0; last_addr = 0; out_ready = 1;
        s_start = 0; s_first = 0; s_last = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        for (int i = 0; i < 32; i++) regs[i] <= 32'(i * 4);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_range_err", range_err, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_data", out_data, 0);
        rst = 0;

        // Table-driven requests
        for (int v = 0; v < 9; v++)
            run_dump(vecs[v].first, vecs[v].last, vecs[v].stall, vecs[v].exp_err, vecs[v].exp_beats);

        // Exact beat timing for 1..3
        regs[1] <= 32'h11111111;
        regs[2] <= 32'h22222222;
        regs[3] <= 32'h33333333;
        @(negedge clk);
        push_range(5'd1, 5'd3);
        hs_q.delete();
        start_cyc = cyc;
        start = 1; first_addr = 1; last_addr = 3; out_ready = 1;
        done_rel = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            start = 0;
            if (done) begin done_rel = cyc - start_cyc; break; end
        end
        #3;
        check("timing_done_cycle", done_rel, 7);
        check("timing_beats", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check("timing_beat0", hs_q[0], 2);
            check("timing_beat1", hs_q[1], 4);
            check("timing_beat2", hs_q[2], 6);
        end
        check("timing_queue_empty", exp_q.size(), 0);

        // Stall pattern 0,0,1,0,1 over range 5..6
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        p = 0;
        seen = 0;
        push_range(5'd5, 5'd6);
        @(negedge clk);
        start = 1; first_addr = 5; last_addr = 6; out_ready = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            start = 0;
            if (done) begin seen = 1; break; end
            if (out_valid && p < 5) begin out_ready = pat[p]; p++; end
            else out_ready = 0;
        end
        #3;
        check("stall_done", seen, 1);
        check("stall_pattern_used", p, 5);
        check("stall_queue_empty", exp_q.size(), 0);
        out_ready = 1;

        // Reset while in SEND at index 10
        for (int i = 1; i < 4; i++) regs[i] <= 32'(i * 4);
        @(negedge clk);
        push_range(5'd0, 5'd31);
        start = 1; first_addr = 0; last_addr = 31; out_ready = 1;
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            start = 0;
            if (out_valid && out_index == 10) begin
                seen = 1;
                out_ready = 0;
                rst = 1;
                break;
            end
        end
        check("rst_reach_idx10", seen, 1);
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_addr", rd_addr, 0);
        exp_q.delete();
        rst = 0;
        out_ready = 1;
        run_dump(5'd0, 5'd31, 1'b0, 1'b0, 32);

        // Snapshot: write x4 on the FETCH edge, with an ignored second start
        @(negedge clk);
        exp_q.push_back({5'd4, 32'd16, 1'b1});
        start = 1; first_addr = 4; last_addr = 4; out_ready = 1;
        p = done_cnt;
        @(negedge clk);
        check("snap_busy", busy, 1);
        wr_en = 1; wr_addr = 4; wr_data = 32'hDEADBEEF;
        start = 1; first_addr = 4; last_addr = 4;
        @(negedge clk);
        wr_en = 0; start = 0;
        repeat (6) @(negedge clk);
        #3;
        check("snap_one_done", done_cnt - p, 1);
        check("snap_queue_empty", exp_q.size(), 0);
        check("snap_idle_busy", busy, 0);
        check("snap_idle_valid", out_valid, 0);
        exp_q.push_back({5'd4, 32'hDEADBEEF, 1'b1});
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        #3;
        check("fresh_queue_empty", exp_q.size(), 0);
        check("fresh_done_count", done_cnt - p, 2);

        // 16-entry instance: out-of-range last_addr values, then the top index
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_start = 1; s_first = 0; s_last = (k == 0) ? 5'd20 : 5'd16;
            @(negedge clk);
            s_start = 0;
            check("n16_err_done", s_done, 1);
            check("n16_err_flag", s_range_err, 1);
            check("n16_err_busy", s_busy, 0);
            check("n16_err_valid", s_out_valid, 0);
            @(negedge clk);
            check("n16_err_clear", {s_done, s_range_err, s_out_valid, s_busy}, 0);
        end
        @(negedge clk);
        s_start = 1; s_first = 15; s_last = 15;
        @(negedge clk);
        s_start = 0;
        check("n16_ok_busy", s_busy, 1);
        @(negedge clk);
        check("n16_beat", {s_out_valid, s_out_index, s_out_data, s_out_last}, {1'b1, 5'd15, 32'd60, 1'b1});
        @(negedge clk);
        check("n16_done", {s_done, s_range_err, s_out_valid}, 3'b100);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/test read-side master for the CPU register file. Drives one combinational read port (address out, data in).
- On a start pulse it walks a programmable register-index range and streams each (index, value) pair out over a valid/ready handshake.
- Used by the bench and by the debug path to snapshot architectural state without touching the datapath write port.

Parameters:
- NUM_REGS, 32, number of architectural registers; indices 0..NUM_REGS-1.
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W >= NUM_REGS.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_addr  in  ADDR_W  first index of the range; sampled with start.
- last_addr  in  ADDR_W  last index of the range, inclusive; sampled with start.
- busy  out  1  high from the cycle after an accepted start until the cycle after the final handshake.
- rd_addr  out  ADDR_W  read-port address to the register file; registered.
- rd_data  in  DATA_W  combinational read data from the register file for rd_addr.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer ready.
- out_index  out  ADDR_W  register index of the current beat.
- out_data  out  DATA_W  register value of the current beat.
- out_last  out  1  high on the final beat of the range.
- done  out  1  one-cycle pulse when a dump completes or is rejected.
- range_err  out  1  high together with done when the request was rejected; otherwise 0.

Behaviour:
- Reset values (next edge after rst=1): state=IDLE; busy, out_valid, out_last, done and range_err =0; rd_addr, out_index and out_data =0.
- rst has priority over every other input. Reset mid-dump aborts with no done pulse and drops out_valid after the reset edge.
- State IDLE:
  - start=1 with first_addr<=last_addr and last_addr<NUM_REGS: latch the range, rd_addr<=first_addr, busy<=1, go to FETCH.
  - start=1 with first_addr>last_addr or last_addr>=NUM_REGS: done<=1 and range_err<=1 for exactly one cycle. No beats are emitted, busy stays 0, state stays IDLE.
  - start=0: hold all outputs; done and range_err return to 0.
- State FETCH (one cycle):
  - At the edge, capture out_data<=rd_data and out_index<=rd_addr.
  - out_last<=(rd_addr==last latched), out_valid<=1, go to SEND.
- State SEND:
  - Hold out_valid, out_index, out_data and out_last stable until out_valid&&out_ready.
  - On handshake with out_last=0: out_valid<=0, rd_addr<=rd_addr+1, go to FETCH.
  - On handshake with out_last=1: out_valid<=0, busy<=0, done<=1 (one cycle), go to IDLE.
- Throughput: one beat per 2 cycles with out_ready held high. Latency from start to first out_valid is 2 cycles.
- Snapshot semantics: each value is sampled at its FETCH edge. A register-file write to that index on the same edge is not visible; later writes do not alter a captured beat.
- start while busy=1 is ignored, with no effect on the range or state.
- Single-entry range (first==last): exactly one beat, with out_last=1.
- Full range 0..NUM_REGS-1: rd_addr never wraps. The increment occurs only when out_last=0, so rd_addr ends at last_addr.
- Index 0 is read like any other index; its value is whatever the register file returns (0 in this CPU).
- done and out_valid are never high in the same cycle.

Test Plan:
- Preload x1=0x11111111, x2=0x22222222, x3=0x33333333. Pulse start with first=1, last=3, out_ready=1 -> beats (1,0x11111111,last0), (2,0x22222222,last0), (3,0x33333333,last1) on cycles 2, 4 and 6 after start; done pulses the cycle after the third handshake; range_err=0.
- Full dump 0..31 with regs[i]=i*4, out_ready=1 -> 32 beats; beat 0 data=0; beat 31 data=0x7C with out_last=1; rd_addr ends at 31; exactly one done pulse.
- Range 5..6 with out_ready toggled 0,0,1,0,1 -> out_data/out_index held stable while stalled; exactly 2 beats; no duplicated or skipped index.
- start with first=7, last=2, then start with last=32 (where representable) or a parameterised NUM_REGS=16 with last=20 -> done=1 and range_err=1 for one cycle each; out_valid never asserts; busy stays 0.
- Dump 0..31 with rst asserted while in SEND at index 10 -> next cycle out_valid=0, busy=0, done=0, rd_addr=0; a new start then produces a clean dump from first_addr.
- Start 4..4 while concurrently writing x4=0xDEADBEEF on the FETCH edge -> beat carries the old value. A second start 4..4 issued while busy is ignored; after completion a fresh start returns 0xDEADBEEF.
